// File: rtl/rpn_pkg.sv
// Shared token codes, FSM states and error codes for the RPN stack evaluator.
package rpn_pkg;

  localparam logic [3:0] TOK_ADD = 4'hA;
  localparam logic [3:0] TOK_SUB = 4'hB;
  localparam logic [3:0] TOK_MUL = 4'hC;
  localparam logic [3:0] TOK_DIV = 4'hD;
  localparam logic [3:0] TOK_EQ  = 4'hE;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_DIV0 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV_WAIT,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Single-cycle binary operators handled by the EXEC state.
  function automatic logic is_alu_tok(input logic [3:0] tok);
    return (tok == TOK_ADD) || (tok == TOK_SUB) || (tok == TOK_MUL);
  endfunction

endpackage

// File: rtl/rpn_stack_eval_if.sv
// Token-in / status-out bundle between the keypad path and the RPN evaluator.
interface rpn_stack_eval_if #(
  parameter int WIDTH = 32,
  parameter int PTR_W = 4
);
  logic             push;
  logic [WIDTH-1:0] operand;
  logic             op_valid;
  logic [3:0]       op_token;
  logic             ready;
  logic [WIDTH-1:0] tos;
  logic [PTR_W-1:0] depth;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             error;
  logic [1:0]       err_code;

  modport master (
    output push, operand, op_valid, op_token,
    input  ready, tos, depth, result, result_valid, error, err_code
  );

  modport slave (
    input  push, operand, op_valid, op_token,
    output ready, tos, depth, result, result_valid, error, err_code
  );
endinterface

// File: rtl/seq_divider.sv
// Signed divider: unsigned restoring core, one quotient bit per cycle, sign fixed on output.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs, nrem, nquo;
  logic [WIDTH:0]   shifted, diff;
  logic             neg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // The first step runs on the load edge so the last bit lands WIDTH-1 edges later.
  always_comb begin
    src_rem = start ? '0 : rem;
    src_quo = start ? mag(dividend) : quo;
    src_dvs = start ? mag(divisor) : dvs;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff    = shifted - {1'b0, src_dvs};
    nrem    = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    nquo    = {src_quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WIDTH - 1);
      rem  <= nrem;
      quo  <= nquo;
      dvs  <= src_dvs;
      neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
        rem <= nrem;
        quo <= nquo;
      end
    end
  end

  assign done     = busy && (cnt == '0);
  assign quotient = neg ? -quo : quo;

endmodule

// File: rtl/rpn_stack_eval.sv
// Postfix evaluator: operand stack, single-cycle add/sub/mul, multi-cycle signed divide.
import rpn_pkg::*;

module rpn_stack_eval #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 4
) (
  input logic              clk,
  input logic              reset,
  input logic              clear,
  rpn_stack_eval_if.slave  bus
);
  localparam int SLOTS = 1 << PTR_W;

  logic [WIDTH-1:0] stk [SLOTS];
  state_e           state, state_nx;
  logic [PTR_W-1:0] depth_q, depth_nx, idx_top, idx_nos, wr_idx;
  logic [WIDTH-1:0] tos_q, result_q, wr_data, a, b, alu;
  logic [1:0]       err_q, err_nx;
  logic [3:0]       op_q;
  logic             soft_rst, wr_en, latch_result;
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_q;
  logic             full, has_two;

  assign soft_rst = !reset || clear;
  assign idx_top  = depth_q - PTR_W'(1);
  assign idx_nos  = depth_q - PTR_W'(2);
  assign a        = stk[idx_nos];
  assign b        = stk[idx_top];
  assign full     = depth_q == PTR_W'(DEPTH);
  assign has_two  = depth_q >= PTR_W'(2);

  always_comb begin
    case (op_q)
      TOK_SUB: alu = a - b;
      TOK_MUL: alu = a * b;
      default: alu = a + b;
    endcase
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (!soft_rst),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_nx     = state;
    depth_nx     = depth_q;
    err_nx       = err_q;
    wr_en        = 1'b0;
    wr_idx       = depth_q;
    wr_data      = bus.operand;
    div_start    = 1'b0;
    latch_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.push) begin
          if (full) begin
            state_nx = ST_ERROR;
            err_nx   = ERR_OVF;
          end else begin
            wr_en    = 1'b1;
            depth_nx = depth_q + PTR_W'(1);
          end
        end else if (bus.op_valid) begin
          if (is_alu_tok(bus.op_token) || bus.op_token == TOK_DIV) begin
            if (!has_two) begin
              state_nx = ST_ERROR;
              err_nx   = ERR_UNF;
            end else if (is_alu_tok(bus.op_token)) begin
              state_nx = ST_EXEC;
            end else if (b == '0) begin
              state_nx = ST_ERROR;
              err_nx   = ERR_DIV0;
            end else begin
              state_nx  = ST_DIV_WAIT;
              div_start = 1'b1;
            end
          end else if (bus.op_token == TOK_EQ) begin
            if (depth_q == PTR_W'(1)) begin
              state_nx     = ST_DONE;
              latch_result = 1'b1;
            end else begin
              state_nx = ST_ERROR;
              err_nx   = ERR_UNF;
            end
          end
        end
      end
      ST_EXEC: begin
        wr_en    = 1'b1;
        wr_idx   = idx_nos;
        wr_data  = alu;
        depth_nx = idx_top;
        state_nx = ST_IDLE;
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          wr_en    = 1'b1;
          wr_idx   = idx_nos;
          wr_data  = div_q;
          depth_nx = idx_top;
          state_nx = ST_IDLE;
        end else if (!div_busy) begin
          // Divider idle without a done pulse: never expected, but do not hang.
          state_nx = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      depth_q  <= '0;
      tos_q    <= '0;
      result_q <= '0;
      err_q    <= ERR_NONE;
      op_q     <= '0;
    end else begin
      depth_q <= depth_nx;
      err_q   <= err_nx;
      if (wr_en)        tos_q    <= wr_data;
      if (latch_result) result_q <= tos_q;
      if (state == ST_IDLE && bus.op_valid) op_q <= bus.op_token;
    end
  end

  // Stack body carries no reset; only entries below depth are ever observed.
  always_ff @(posedge clk) begin
    if (wr_en && !soft_rst) stk[wr_idx] <= wr_data;
  end

  assign bus.ready        = state == ST_IDLE;
  assign bus.tos          = tos_q;
  assign bus.depth        = depth_q;
  assign bus.result       = result_q;
  assign bus.result_valid = state == ST_DONE;
  assign bus.error        = state == ST_ERROR;
  assign bus.err_code     = err_q;

endmodule

// File: tb/tb_rpn_stack_eval.sv
// Directed plus randomized checks of rpn_stack_eval against a queue-based RPN model.
module tb_rpn_stack_eval;
  localparam int W = 32;
  localparam int D = 8;
  localparam int P = 4;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  rpn_stack_eval_if #(.WIDTH(W), .PTR_W(P)) bus();

  rpn_stack_eval #(.WIDTH(W), .DEPTH(D), .PTR_W(P)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: operand stack as a queue, pending op result applied after m_wait cycles.
  logic [W-1:0] m_stk[$];
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_pend = '0;
  logic         m_rv = 1'b0;
  logic         m_err = 1'b0;
  logic [1:0]   m_code = 2'd0;
  int           m_wait = 0;
  bit           m_live = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sdiv(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    if (x == MIN_NEG && y == '1) return MIN_NEG;
    return sx / sy;
  endfunction

  task automatic m_fail(input logic [1:0] code);
    m_err  = 1'b1;
    m_code = code;
  endtask

  task automatic m_eval(input logic [3:0] tok);
    int n;
    logic [W-1:0] x, y;
    n = m_stk.size();
    if (tok >= 4'hA && tok <= 4'hD) begin
      if (n < 2) m_fail(2'd2);
      else begin
        x = m_stk[n-2];
        y = m_stk[n-1];
        case (tok)
          4'hA: begin m_pend = x + y; m_wait = 1; end
          4'hB: begin m_pend = x - y; m_wait = 1; end
          4'hC: begin m_pend = x * y; m_wait = 1; end
          default: begin
            if (y == '0) m_fail(2'd3);
            else begin m_pend = sdiv(x, y); m_wait = W; end
          end
        endcase
      end
    end else if (tok == 4'hE) begin
      if (n == 1) begin m_res = m_stk[0]; m_rv = 1'b1; end
      else m_fail(2'd2);
    end
  endtask

  always @(posedge clk) begin
    if (!reset || clear) begin
      m_stk.delete();
      m_res = '0; m_rv = 1'b0; m_err = 1'b0; m_code = 2'd0; m_wait = 0; m_live = 1'b1;
    end else if (m_live) begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          void'(m_stk.pop_back());
          m_stk[m_stk.size()-1] = m_pend;
        end
      end else if (m_rv || m_err) begin
      end else if (bus.push) begin
        if (m_stk.size() == D) m_fail(2'd1);
        else m_stk.push_back(bus.operand);
      end else if (bus.op_valid) begin
        m_eval(bus.op_token);
      end
    end
  end

  always @(posedge clk)
    assert (!(bus.push && bus.op_valid)) else $error("push and op_valid driven together");

  always @(negedge clk) begin
    if (m_live) begin
      check("ready", W'(bus.ready), W'(m_wait == 0 && !m_rv && !m_err));
      check("tos", bus.tos, (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1]);
      check("depth", W'(bus.depth), W'(m_stk.size()));
      check("result", bus.result, m_res);
      check("result_valid", W'(bus.result_valid), W'(m_rv));
      check("error", W'(bus.error), W'(m_err));
      check("err_code", W'(bus.err_code), W'(m_code));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_push(input logic [W-1:0] v);
    bus.push = 1'b1; bus.operand = v;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] t);
    bus.op_valid = 1'b1; bus.op_token = t;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 200) begin tick(); n++; end
    if (!bus.ready) begin
      total++; bad++;
      $display("FAIL wait_ready: ready still %b after %0d cycles, need 1", bus.ready, n);
    end
  endtask

  // Issues a divide, pokes strobes while busy and returns ready-low cycle count.
  task automatic divide(input logic [W-1:0] x, input logic [W-1:0] y, output int lo);
    do_reset();
    do_push(x);
    do_push(y);
    do_op(4'hD);
    lo = 0;
    while (!bus.ready && lo < 100) begin
      bus.push = (lo == 5); bus.operand = 32'h55;
      bus.op_valid = (lo == 10); bus.op_token = 4'hA;
      tick();
      lo++;
    end
    bus.push = 1'b0; bus.op_valid = 1'b0;
  endtask

  initial begin
    int lo;
    int r;
    bus.push = 1'b0; bus.op_valid = 1'b0; bus.op_token = 4'h0; bus.operand = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("lit_reset_ready", W'(bus.ready), W'(1));
    check("lit_reset_depth", W'(bus.depth), '0);
    check("lit_reset_tos", bus.tos, '0);

    do_push(3); do_push(4); do_op(4'hA); wait_ready();
    check("lit_add_tos", bus.tos, 32'd7);
    do_push(2); do_op(4'hC); wait_ready();
    check("lit_mul_tos", bus.tos, 32'd14);
    do_op(4'hE);
    check("lit_eq_result", bus.result, 32'd14);
    check("lit_eq_rv", W'(bus.result_valid), W'(1));
    check("lit_eq_depth", W'(bus.depth), W'(1));
    check("lit_eq_code", W'(bus.err_code), '0);

    do_reset();
    do_push(7); do_push(10); do_op(4'hB); wait_ready();
    check("lit_sub_tos", bus.tos, 32'hFFFF_FFFD);
    do_op(4'hE);
    check("lit_sub_result", bus.result, 32'hFFFF_FFFD);

    divide(32'd100, 32'd7, lo);
    check("lit_div_ready_low", W'(lo), W'(32));
    check("lit_div_tos", bus.tos, 32'd14);
    check("lit_div_depth", W'(bus.depth), W'(1));
    divide(32'hFFFF_FFF9, 32'd2, lo);
    check("lit_div_neg_tos", bus.tos, 32'hFFFF_FFFD);
    divide(32'd7, 32'hFFFF_FFFE, lo);
    check("lit_div_negd_tos", bus.tos, 32'hFFFF_FFFD);
    divide(MIN_NEG, 32'hFFFF_FFFF, lo);
    check("lit_div_minneg", bus.tos, MIN_NEG);

    do_reset();
    do_push(5); do_push(0); do_op(4'hD);
    check("lit_div0_error", W'(bus.error), W'(1));
    check("lit_div0_code", W'(bus.err_code), W'(3));
    check("lit_div0_depth", W'(bus.depth), W'(2));
    do_push(1); do_op(4'hA); tick();
    check("lit_sticky_depth", W'(bus.depth), W'(2));
    check("lit_sticky_code", W'(bus.err_code), W'(3));

    do_reset();
    do_push(5); do_op(4'hA);
    check("lit_unf_code", W'(bus.err_code), W'(2));

    do_reset();
    for (int i = 0; i < 9; i++) do_push(W'(i + 1));
    check("lit_ovf_code", W'(bus.err_code), W'(1));
    check("lit_ovf_depth", W'(bus.depth), W'(8));

    do_reset();
    do_push(1); do_push(2); do_op(4'hE);
    check("lit_eq_two_code", W'(bus.err_code), W'(2));
    do_reset();
    do_op(4'hE);
    check("lit_eq_empty_code", W'(bus.err_code), W'(2));
    do_reset();
    do_op(4'h3); do_op(4'hF);
    check("lit_illegal_error", W'(bus.error), '0);
    check("lit_illegal_ready", W'(bus.ready), W'(1));

    do_reset();
    do_push(100); do_push(7); do_op(4'hD);
    repeat (9) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    check("lit_abort_ready", W'(bus.ready), W'(1));
    check("lit_abort_depth", W'(bus.depth), '0);
    repeat (40) tick();
    check("lit_abort_tos", bus.tos, '0);
    do_push(9);
    check("lit_abort_push", bus.tos, 32'd9);

    do_op(4'hE);
    check("lit_done_rv", W'(bus.result_valid), W'(1));
    clear = 1'b1; tick(); clear = 1'b0;
    check("lit_clear_depth", W'(bus.depth), '0);
    check("lit_clear_ready", W'(bus.ready), W'(1));

    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if ((m_rv || m_err) && r < 25) clear = 1'b1;
      else if (r == 99) reset = 1'b0;
      else if (r < 40) begin
        bus.push = 1'b1;
        bus.operand = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                                  : W'(int'($urandom_range(0, 40)) - 20);
      end else if (r < 70) begin
        bus.op_valid = 1'b1;
        bus.op_token = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(10, 14));
      end
      tick();
      bus.push = 1'b0; bus.op_valid = 1'b0; clear = 1'b0; reset = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
